// File: rtl/ssd_scan_mux.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with a double-buffered value.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module ssd_scan_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter int GUARD_CYCLES     = 8,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  output logic [3:0]                    nibble,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]    GUARD     = PW'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           presc, presc_n;
  logic [IDX_W-1:0]        idx_n;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_n, display, display_n;
  logic                    pending, pending_n;
  logic [3:0]              nibble_n;
  logic [NUM_DIGITS-1:0]   on_n, anode_n;
  logic                    tick, wrap, blank, upper_zero, lit;

  // Every output is computed from the next-state values so that it lines up
  // with the registered prescaler and digit index on the same edge.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    tick       = (presc == PRESC_MAX);
    wrap       = en && tick && (digit_idx == IDX_MAX);
    presc_n    = '0;
    idx_n      = '0;
    shadow_n   = load ? value_in : shadow;
    display_n  = display;
    pending_n  = pending;
    upper_zero = 1'b1;
    blank      = 1'b0;
    on_n       = '0;

    if (en) begin
      presc_n = tick ? '0 : presc + 1'b1;
      if (tick) idx_n = (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
      else      idx_n = digit_idx;
    end

    // A load coinciding with the wrap bypasses the shadow so the new frame shows it at once.
    if (wrap) begin
      pending_n = 1'b0;
      if (load)         display_n = value_in;
      else if (pending) display_n = shadow;
    end else if (load) begin
      pending_n = 1'b1;
    end

    nibble_n = display_n[4*idx_n +: 4];

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_n) && display_n[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_n != '0) && upper_zero;
`else
    blank = 1'b0;
`endif

    lit = en && (presc_n >= GUARD) && !blank;
    if (lit) on_n[idx_n] = 1'b1;
    anode_n = (ANODE_ACTIVE_LOW != 0) ? ~on_n : on_n;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      digit_idx  <= '0;
      // NOTE: the value buffers are plain registers, cleared with everything else.
      shadow     <= '0;
      display    <= '0;
      pending    <= 1'b0;
      nibble     <= 4'h0;
      anode      <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      presc      <= presc_n;
      digit_idx  <= idx_n;
      shadow     <= shadow_n;
      display    <= display_n;
      pending    <= pending_n;
      nibble     <= nibble_n;
      anode      <= anode_n;
      frame_done <= wrap;
    end
  end

endmodule
